// File: rtl/opll_write_queue.sv
// opll_write_queue: buffers host {A0,D} writes and replays them as paced OPLL CS_n/WR_n bus cycles
module opll_write_queue #(
    parameter int DEPTH      = 4,
    parameter int STROBE_LEN = 2,
    parameter int ADDR_WAIT  = 12,
    parameter int DATA_WAIT  = 84
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cen,
    input  logic                         in_valid,
    input  logic                         in_a0,
    input  logic [7:0]                   in_data,
    output logic                         in_ready,
    output logic                         opll_cs_n,
    output logic                         opll_wr_n,
    output logic                         opll_a0,
    output logic [7:0]                   opll_d,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         busy,
    output logic                         overflow,
    input  logic                         clr_ovf
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = $clog2(DEPTH + 1);
    localparam int MAXC = (STROBE_LEN > ADDR_WAIT) ?
                          ((STROBE_LEN > DATA_WAIT) ? STROBE_LEN : DATA_WAIT) :
                          ((ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STROBE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam logic [CW-1:0] C_STROBE = CW'(STROBE_LEN - 1);
    localparam logic [CW-1:0] C_ADDR   = CW'(ADDR_WAIT - 1);
    localparam logic [CW-1:0] C_DATA   = CW'(DATA_WAIT - 1);

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [LW-1:0] r_level;
    logic          r_ovf;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_cs_n, r_wr_n, r_a0;
    logic [7:0]    r_d;

    logic          w_full, w_push, w_pop;
    logic [8:0]    w_head;

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_push    = in_valid & ~w_full;
    assign w_pop     = cen & (r_state == S_IDLE) & (r_level != '0);
    assign w_head    = r_mem[r_rp];

    assign in_ready  = ~w_full;
    assign level     = r_level;
    assign overflow  = r_ovf;
    assign busy      = (r_state != S_IDLE) | (r_level != '0);
    assign opll_cs_n = r_cs_n;
    assign opll_wr_n = r_wr_n;
    assign opll_a0   = r_a0;
    assign opll_d    = r_d;

    // FIFO storage: entries need no reset, occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {in_a0, in_data};
    end

    // FIFO pointers, occupancy and sticky drop flag (a drop beats a clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= r_rp + AW'(w_pop);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            r_ovf   <= (in_valid & w_full) | (r_ovf & ~clr_ovf);
        end
    end

    // Bus sequencer: strobe for STROBE_LEN cen pulses, then hold off for the OPLL recovery time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_a0    <= 1'b0;
            r_d     <= '0;
        end else if (cen) begin
            case (r_state)
                S_IDLE: if (w_pop) begin
                    r_a0    <= w_head[8];
                    r_d     <= w_head[7:0];
                    r_cs_n  <= 1'b0;
                    r_wr_n  <= 1'b0;
                    r_cnt   <= C_STROBE;
                    r_state <= S_STROBE;
                end
                S_STROBE: if (r_cnt == '0) begin
                    r_cs_n  <= 1'b1;
                    r_wr_n  <= 1'b1;
                    r_cnt   <= r_a0 ? C_DATA : C_ADDR;
                    r_state <= S_WAIT;
                end else begin
                    r_cnt   <= r_cnt - CW'(1);
                end
                S_WAIT: if (r_cnt == '0) r_state <= S_IDLE;
                        else r_cnt <= r_cnt - CW'(1);
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_opll_write_queue.sv
// tb_opll_write_queue: scoreboard bench; stimulus queues expected strobes, a monitor checks each wr_n cycle
module tb_opll_write_queue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen_man = 1'b0;
    logic       cdiv = 1'b0;
    logic [1:0] ph = 2'd0;
    logic       cen;
    logic       in_valid = 1'b0;
    logic       in_a0 = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       in_ready, opll_cs_n, opll_wr_n, opll_a0, busy, overflow;
    logic [7:0] opll_d;
    logic [2:0] level;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [8:0] exp_q[$];
    int         fall_t[$];
    int         exp_low = 2;
    int         low_cnt = 0;
    logic       prev_wr = 1'b1;
    bit         skip_width = 1'b0;
    logic [8:0] mon_e;

    assign cen = cdiv ? (ph == 2'd0) : cen_man;

    opll_write_queue dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .in_valid(in_valid), .in_a0(in_a0),
        .in_data(in_data), .in_ready(in_ready), .opll_cs_n(opll_cs_n), .opll_wr_n(opll_wr_n),
        .opll_a0(opll_a0), .opll_d(opll_d), .level(level), .busy(busy), .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // Cycle counter and divided clock-enable phase
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ph  <= ph + 2'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    // Monitor: every wr_n fall pops the scoreboard, every rise checks the strobe width
    always @(negedge clk) begin
        if (!opll_wr_n) low_cnt++;
        if (!opll_wr_n && prev_wr) begin
            fall_t.push_back(cyc);
            chk("cs_n_with_wr_n", opll_cs_n, 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got a0=%0b d=0x%02h required no strobe", opll_a0, opll_d);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_a0_d", {opll_a0, opll_d}, mon_e);
            end
        end
        if (opll_wr_n && !prev_wr) begin
            if (!skip_width) chk("wr_n_low_width", low_cnt, exp_low);
            skip_width = 1'b0;
            low_cnt = 0;
        end
        prev_wr = opll_wr_n;
    end

    task automatic push(input logic a, input logic [7:0] dd, input bit acc);
        in_valid = 1'b1;
        in_a0    = a;
        in_data  = dd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc) exp_q.push_back({a, dd});
    endtask

    task automatic wait_falls(input int n, input int lim);
        int i = 0;
        while (fall_t.size() < n && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk("strobe_count", fall_t.size(), n);
    endtask

    task automatic wait_idle(input int lim);
        int i = 0;
        while (busy && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk("reach_idle", busy, 0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t1_cs_n", opll_cs_n, 1);
        chk("t1_wr_n", opll_wr_n, 1);
        chk("t1_a0", opll_a0, 0);
        chk("t1_d", opll_d, 8'h00);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_level", level, 0);
        chk("t1_busy", busy, 0);
        chk("t1_overflow", overflow, 0);
        @(posedge clk);
        #1;

        // T2: address then data write at full rate
        cen_man = 1'b1;
        fall_t.delete();
        push(1'b0, 8'h30, 1);
        push(1'b1, 8'h15, 1);
        wait_falls(2, 200);
        wait_idle(300);
        if (fall_t.size() >= 2) begin
            chk("t2_fall_gap", fall_t[1] - fall_t[0], 15);
            chk("t2_busy_drop", cyc - fall_t[1], 86);
        end

        // T3: fill with cen stopped, overflow and clear, then drain
        cen_man = 1'b0;
        fall_t.delete();
        push(1'b0, 8'h10, 1);
        push(1'b1, 8'h20, 1);
        push(1'b0, 8'h30, 1);
        push(1'b1, 8'h40, 1);
        chk("t3_level_full", level, 4);
        chk("t3_in_ready_full", in_ready, 0);
        chk("t3_no_ovf_yet", overflow, 0);
        push(1'b0, 8'h55, 0);
        chk("t3_overflow_set", overflow, 1);
        chk("t3_level_kept", level, 4);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        chk("t3_overflow_clr", overflow, 0);
        cen_man = 1'b1;
        wait_falls(4, 1000);
        wait_idle(500);
        chk("t3_exact_strobes", fall_t.size(), 4);
        chk("t3_scoreboard_empty", exp_q.size(), 0);

        // T4: cen every 4th clock
        cdiv = 1'b1;
        exp_low = 8;
        fall_t.delete();
        push(1'b0, 8'h20, 1);
        push(1'b1, 8'h07, 1);
        wait_falls(2, 400);
        wait_idle(800);
        if (fall_t.size() >= 2) chk("t4_fall_gap", fall_t[1] - fall_t[0], 60);
        cdiv = 1'b0;
        exp_low = 2;

        // T5: reset during a strobe discards the queue
        cen_man = 1'b0;
        fall_t.delete();
        push(1'b0, 8'hA1, 1);
        push(1'b1, 8'hA2, 0);
        push(1'b0, 8'hA3, 0);
        push(1'b1, 8'hA4, 0);
        cen_man = 1'b1;
        wait_falls(1, 20);
        chk("t5_in_strobe", opll_wr_n, 0);
        chk("t5_level_before", level, 3);
        #1;
        skip_width = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t5_wr_n_reset", opll_wr_n, 1);
        chk("t5_cs_n_reset", opll_cs_n, 1);
        chk("t5_level_reset", level, 0);
        #20;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("t5_no_more_strobes", fall_t.size(), 1);
        chk("t5_idle", busy, 0);

        // T6: refused push while full and popping, accepted next cycle
        @(posedge clk);
        #1;
        cen_man = 1'b0;
        fall_t.delete();
        push(1'b0, 8'h41, 1);
        push(1'b1, 8'h42, 1);
        push(1'b0, 8'h43, 1);
        push(1'b1, 8'h44, 1);
        chk("t6_level_full", level, 4);
        in_valid = 1'b1;
        in_a0    = 1'b1;
        in_data  = 8'h99;
        cen_man  = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_level_after_pop", level, 3);
        chk("t6_in_ready_reopen", in_ready, 1);
        chk("t6_ovf_on_refused", overflow, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back({1'b1, 8'h99});
        chk("t6_level_accepted", level, 4);
        wait_falls(5, 1500);
        wait_idle(500);
        chk("t6_scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
